// File: rtl/mdf_out_pkg.sv
// Shared types and default widths for the multi_dataflow output collector.
package mdf_out_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int LEN_W_DEF  = 16;
  localparam int DEPTH_DEF  = 4;
  localparam int PTR_W      = $clog2(DEPTH_DEF);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mdf_out_fifo.sv
// First-word-fall-through FIFO; when empty the head keeps showing the last word
// popped, which is still intact in the slot just behind the read pointer.
module mdf_out_fifo
  import mdf_out_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      push,
  input  logic                      pop,
  input  logic [DATA_W-1:0]         din,
  output logic [DATA_W-1:0]         dout,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      full,
  output logic                      empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     last_ptr;
  logic              do_push;
  logic              do_pop;

  assign full     = (count == (AW + 1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign last_ptr = rd_ptr - 1'b1;
  assign dout     = empty ? mem[last_ptr] : mem[rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mdf_out_collector.sv
// Collects the outStream0 write/full stream into a FWFT FIFO, re-presents it as
// valid/ready and pulses done once a job's last word has left. MDF_OUT_COLLECTOR_PERF_EN adds stall_cyc.
module mdf_out_collector
  import mdf_out_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  reg_len,
  input  logic [DATA_W-1:0] mdf_data,
  input  logic              mdf_wr,
  output logic              mdf_full,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
`ifdef MDF_OUT_COLLECTOR_PERF_EN
  ,
  output logic [31:0]       stall_cyc
`endif
);

  localparam int AW = $clog2(DEPTH);

  state_t            state;
  state_t            state_nxt;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt;
  logic [LEN_W-1:0]  cnt_inc;
  logic [AW:0]       fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              accept_start;

  assign cnt_inc      = cnt + 1'b1;
  assign push         = mdf_wr & ~mdf_full;
  assign pop          = out_valid & out_ready;
  assign out_valid    = ~fifo_empty;
  assign accept_start = (state == IDLE) & start;

  mdf_out_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (mdf_data),
    .dout  (out_data),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (reg_len == '0) ? DONE : RUN;
      RUN:     if (push && (cnt_inc == len_q)) state_nxt = DRAIN;
      DRAIN:   if (fifo_count == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    done     = (state == DONE);
    mdf_full = (state != RUN) | fifo_full;
  end

  // cnt never exceeds len_q, so the largest job length finishes without wrapping.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      len_q <= '0;
      cnt   <= '0;
    end else if (accept_start) begin
      len_q <= reg_len;
      cnt   <= '0;
    end else if (push) begin
      cnt   <= cnt_inc;
    end
  end

`ifdef MDF_OUT_COLLECTOR_PERF_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cyc <= '0;
    end else if (accept_start) begin
      stall_cyc <= '0;
    end else if (busy && out_valid && !out_ready && !(&stall_cyc)) begin
      stall_cyc <= stall_cyc + 1'b1;
    end
  end
`endif

endmodule
